vga_frame_receiver: RTL and testbench

//  Receiving end of the game's VGA link: samples hsync/vsync/RGB in the pixel-clock domain and recovers pixel coordinates.

---
 rtl/vga_frame_receiver.sv | 191 +++++++++++++++++++
 tb/tb_vga_frame_receiver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_receiver.sv
// VGA link receiver: samples sync/RGB, recovers pixel coordinates, verifies frame timing
// and reports the per-frame bounding box of pixels matching the target colour.
module vga_frame_receiver #(
  parameter int          H_SYNC  = 96,
  parameter int          H_BP    = 48,
  parameter int          H_ACT   = 640,
  parameter int          H_FP    = 16,
  parameter int          V_SYNC  = 2,
  parameter int          V_BP    = 33,
  parameter int          V_ACT   = 480,
  parameter int          V_FP    = 10,
  parameter logic [11:0] TGT_RGB = 12'hFF0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [3:0] red,
  input  logic [3:0] green,
  input  logic [3:0] blue,
  output logic       locked,
  output logic       pixel_valid,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_done,
  output logic       obj_found,
  output logic [9:0] obj_x_min,
  output logic [9:0] obj_x_max,
  output logic [9:0] obj_y_min,
  output logic [9:0] obj_y_max,
  output logic [7:0] err_count
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam logic [9:0] L_H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] L_H_SYNC  = 10'(H_SYNC);
  localparam logic [9:0] L_H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] L_H_END   = 10'(H_TOTAL - H_FP);
  localparam logic [9:0] L_V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] L_V_SYNC  = 10'(V_SYNC);
  localparam logic [9:0] L_V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] L_V_END   = 10'(V_TOTAL - V_FP);
  localparam logic [9:0] L_CNT_MAX = 10'd1023;
  localparam logic [9:0] L_CNT_PRE = 10'd1022;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_hs1, r_vs1, r_hs2, r_vs2;
  logic [11:0] r_rgb1;
  logic [9:0]  r_h_cnt, r_v_cnt, w_h_nxt, w_v_nxt;
  logic        r_skip_h, r_skip_v, r_acq_err;
  logic        r_hit;
  logic [9:0]  r_bx_min, r_bx_max, r_by_min, r_by_max;

  logic       w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise;
  logic       w_active, w_tgt, w_err, w_lk, w_enter_acq;
  logic [9:0] w_x, w_y;

  assign w_hs_fall = r_hs2 & ~r_hs1;
  assign w_hs_rise = ~r_hs2 & r_hs1;
  assign w_vs_fall = r_vs2 & ~r_vs1;
  assign w_vs_rise = ~r_vs2 & r_vs1;
  assign w_lk      = (r_state == ST_LOCKED);
  assign w_tgt     = (r_rgb1 == TGT_RGB);

  // Counter values belonging to the sample now held in stage 1
  always_comb begin
    w_h_nxt = r_h_cnt;
    w_v_nxt = r_v_cnt;
    if (w_hs_fall) begin
      w_h_nxt = 10'd0;
    end else if (r_h_cnt != L_CNT_MAX) begin
      w_h_nxt = r_h_cnt + 10'd1;
    end else begin
      w_h_nxt = r_h_cnt;
    end
    if (w_vs_fall) begin
      w_v_nxt = 10'd0;
    end else if (w_hs_fall && (r_v_cnt != L_CNT_MAX)) begin
      w_v_nxt = r_v_cnt + 10'd1;
    end else begin
      w_v_nxt = r_v_cnt;
    end
  end

  assign w_active = (w_h_nxt >= L_H_START) && (w_h_nxt < L_H_END) &&
                    (w_v_nxt >= L_V_START) && (w_v_nxt < L_V_END);
  assign w_x      = w_h_nxt - L_H_START;
  assign w_y      = w_v_nxt - L_V_START;

  // Falls are checked against the count of the preceding sample, rises against the new one
  assign w_err = (w_hs_fall && !r_skip_h && (r_h_cnt != L_H_LAST)) ||
                 (w_hs_rise && (w_h_nxt != L_H_SYNC)) ||
                 (w_vs_fall && !r_skip_v && (r_v_cnt != L_V_LAST)) ||
                 (w_vs_rise && (w_v_nxt != L_V_SYNC)) ||
                 (!w_hs_fall && (r_h_cnt == L_CNT_PRE));

  assign w_enter_acq = w_vs_fall && ((r_state == ST_HUNT) ||
                       ((r_state == ST_ACQUIRE) && (r_acq_err || w_err)));

  // Lock state machine next-state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HUNT: begin
        if (w_vs_fall) w_state_nxt = ST_ACQUIRE;
        else           w_state_nxt = ST_HUNT;
      end
      ST_ACQUIRE: begin
        if (w_vs_fall && !w_err && !r_acq_err) w_state_nxt = ST_LOCKED;
        else                                   w_state_nxt = ST_ACQUIRE;
      end
      ST_LOCKED: begin
        if (w_err) w_state_nxt = ST_HUNT;
        else       w_state_nxt = ST_LOCKED;
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  // Input stage, counters, state and acquisition bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hs1 <= 1'b1;  r_vs1 <= 1'b1;  r_hs2 <= 1'b1;  r_vs2 <= 1'b1;
      r_rgb1 <= 12'h000;
      r_h_cnt <= 10'd0;  r_v_cnt <= 10'd0;
      r_state <= ST_HUNT;
      r_skip_h <= 1'b0;  r_skip_v <= 1'b0;  r_acq_err <= 1'b0;
    end else begin
      r_hs1  <= hsync;  r_vs1 <= vsync;  r_rgb1 <= {red, green, blue};
      r_hs2  <= r_hs1;  r_vs2 <= r_vs1;
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
      r_state <= w_state_nxt;
      if (w_enter_acq) begin
        r_skip_h <= 1'b1;
        r_skip_v <= 1'b1;
      end else begin
        if (w_hs_fall) r_skip_h <= 1'b0;
        if (w_vs_fall) r_skip_v <= 1'b0;
      end
      if ((r_state == ST_ACQUIRE) && !w_vs_fall) r_acq_err <= r_acq_err | w_err;
      else                                       r_acq_err <= 1'b0;
    end
  end

  // Registered outputs and running bounding box
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      locked <= 1'b0;  pixel_valid <= 1'b0;  pixel_x <= 10'd0;  pixel_y <= 10'd0;
      frame_done <= 1'b0;  obj_found <= 1'b0;  err_count <= 8'd0;
      obj_x_min <= 10'd0;  obj_x_max <= 10'd0;  obj_y_min <= 10'd0;  obj_y_max <= 10'd0;
      r_hit <= 1'b0;
      r_bx_min <= 10'd0;  r_bx_max <= 10'd0;  r_by_min <= 10'd0;  r_by_max <= 10'd0;
    end else begin
      locked      <= (w_state_nxt == ST_LOCKED);
      pixel_valid <= w_active && w_lk;
      pixel_x     <= w_active ? w_x : 10'd0;
      pixel_y     <= w_active ? w_y : 10'd0;
      frame_done  <= w_lk && w_vs_fall && !w_err;
      if (w_lk && w_err && (err_count != 8'd255)) err_count <= err_count + 8'd1;
      if (w_lk && w_vs_fall && !w_err) begin
        obj_found <= r_hit;
        if (r_hit) begin
          obj_x_min <= r_bx_min;  obj_x_max <= r_bx_max;
          obj_y_min <= r_by_min;  obj_y_max <= r_by_max;
        end
        r_hit <= 1'b0;
        r_bx_min <= 10'd0;  r_bx_max <= 10'd0;  r_by_min <= 10'd0;  r_by_max <= 10'd0;
      end else if (w_lk && !w_err) begin
        if (w_active && w_tgt) begin
          r_hit    <= 1'b1;
          r_bx_min <= (!r_hit || (w_x < r_bx_min)) ? w_x : r_bx_min;
          r_bx_max <= (!r_hit || (w_x > r_bx_max)) ? w_x : r_bx_max;
          r_by_min <= (!r_hit || (w_y < r_by_min)) ? w_y : r_by_min;
          r_by_max <= (!r_hit || (w_y > r_by_max)) ? w_y : r_by_max;
        end
      end else begin
        r_hit <= 1'b0;
        r_bx_min <= 10'd0;  r_bx_max <= 10'd0;  r_by_min <= 10'd0;  r_by_max <= 10'd0;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_receiver.sv
// Scoreboard bench for vga_frame_receiver using a reduced raster (14x9 clocks per frame).
module tb_vga_frame_receiver;
  localparam int HS = 2, HB = 2, HA = 8, HF = 2, HT = HS + HB + HA + HF;
  localparam int VS = 1, VB = 1, VA = 6, VF = 1, VT = VS + VB + VA + VF;
  localparam int HST = HS + HB, VST = VS + VB;

  logic       clk = 1'b0, reset = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [3:0] red = 4'h0, green = 4'h0, blue = 4'h0;
  logic       locked, pixel_valid, frame_done, obj_found;
  logic [9:0] pixel_x, pixel_y, obj_x_min, obj_x_max, obj_y_min, obj_y_max;
  logic [7:0] err_count;

  vga_frame_receiver #(.H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
                       .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
                       .TGT_RGB(12'hFF0)) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .locked(locked), .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_done(frame_done), .obj_found(obj_found),
    .obj_x_min(obj_x_min), .obj_x_max(obj_x_max), .obj_y_min(obj_y_min), .obj_y_max(obj_y_max),
    .err_count(err_count));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int x; int y;} pix_t;
  typedef struct {bit found; int xmin; int xmax; int ymin; int ymax;} frm_t;
  typedef struct {bit lk; int err; int at;} ev_t;
  pix_t pix_q[$];
  frm_t frm_q[$];
  ev_t  ev_q[$];

  int n_tests = 0, n_fail = 0;
  int pat = 0, exp_err = 0;
  bit prev_lk = 1'b0;

  task automatic chk(input string name, input bit ok, input string got, input string want);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic bit is_act(input int h, input int ln);
    return (h >= HST) && (h < HT - HF) && (ln >= VST) && (ln < VT - VF);
  endfunction

  // pattern 1: 5x5 block at x 2..6, y 1..5; pattern 2: two corners plus target colour in all blanking
  function automatic logic [11:0] colour(input int h, input int ln);
    int x, y;
    x = h - HST;
    y = ln - VST;
    case (pat)
      1: if (is_act(h, ln) && x >= 2 && x <= 6 && y >= 1 && y <= 5) return 12'hFF0;
      2: if (!is_act(h, ln) || (x == 0 && y == 0) || (x == HA - 1 && y == VA - 1)) return 12'hFF0;
      default: ;
    endcase
    return (((h + ln) % 3) == 0) ? 12'hFF1 : 12'h0A0;
  endfunction

  task automatic drive(input bit hs, input bit vs, input logic [11:0] c);
    @(posedge clk);
    #1;
    hsync = hs;
    vsync = vs;
    {red, green, blue} = c;
  endtask

  task automatic push_frm(input bit f, input int a, input int b, input int c, input int d);
    frm_t e;
    e.found = f; e.xmin = a; e.xmax = b; e.ymin = c; e.ymax = d;
    frm_q.push_back(e);
  endtask

  task automatic send_line(input int len, input bit vs_low, input int ln, input bit pix,
                           input int ev_idx, input bit ev_lk, input int ev_err);
    ev_t  e;
    pix_t p;
    for (int h = 0; h < len; h++) begin
      drive(h >= HS, !vs_low, colour(h, ln));
      if (h == ev_idx) begin
        e.lk = ev_lk; e.err = ev_err; e.at = cyc + 2;
        ev_q.push_back(e);
      end
      if (pix && h < HT && is_act(h, ln)) begin
        p.x = h - HST; p.y = ln - VST;
        pix_q.push_back(p);
      end
    end
  endtask

  // long_ln >= 0 stretches that line by one clock; the next hsync fall is then an error
  task automatic send_frame(input bit pix, input bit lock_ev, input int long_ln);
    int len, ei, ee;
    bit p, elk;
    for (int ln = 0; ln < VT; ln++) begin
      len = (ln == long_ln) ? HT + 1 : HT;
      p   = pix && ((long_ln < 0) || (ln <= long_ln));
      ei = -1; elk = 1'b0; ee = 0;
      if (ln == 0 && lock_ev) begin
        ei = 0; elk = 1'b1; ee = exp_err;
      end
      if (long_ln >= 0 && ln == long_ln + 1) begin
        exp_err = sat255(exp_err + 1);
        ei = 0; elk = 1'b0; ee = exp_err;
      end
      send_line(len, ln < VS, ln, p, ei, elk, ee);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a pixel, a frame result or a lock change
  always @(negedge clk) begin
    pix_t p;
    frm_t f;
    ev_t  e;
    if (pixel_valid) begin
      if (pix_q.size() == 0) begin
        chk("pixel_unexpected", 1'b0, $sformatf("(%0d,%0d)", pixel_x, pixel_y), "no pixel");
      end else begin
        p = pix_q.pop_front();
        chk("pixel_xy", int'(pixel_x) == p.x && int'(pixel_y) == p.y,
            $sformatf("(%0d,%0d)", pixel_x, pixel_y), $sformatf("(%0d,%0d)", p.x, p.y));
      end
    end
    if (frame_done) begin
      if (frm_q.size() == 0) begin
        chk("frame_done_unexpected", 1'b0, "frame_done=1", "no frame_done");
      end else begin
        f = frm_q.pop_front();
        chk("frame_box", obj_found == f.found && int'(obj_x_min) == f.xmin &&
            int'(obj_x_max) == f.xmax && int'(obj_y_min) == f.ymin && int'(obj_y_max) == f.ymax,
            $sformatf("found=%0d x=%0d..%0d y=%0d..%0d", obj_found, obj_x_min, obj_x_max, obj_y_min, obj_y_max),
            $sformatf("found=%0d x=%0d..%0d y=%0d..%0d", f.found, f.xmin, f.xmax, f.ymin, f.ymax));
      end
    end
    if (locked != prev_lk) begin
      if (ev_q.size() == 0) begin
        chk("lock_unexpected", 1'b0, $sformatf("locked=%0d", locked), "no change");
      end else begin
        e = ev_q.pop_front();
        chk("lock_event", locked == e.lk && int'(err_count) == e.err && (e.at < 0 || e.at == cyc),
            $sformatf("locked=%0d err=%0d cyc=%0d", locked, err_count, cyc),
            $sformatf("locked=%0d err=%0d cyc=%0d", e.lk, e.err, e.at));
      end
    end
    prev_lk <= locked;
  end

  task automatic chk_zero(input string name);
    chk(name, {locked, pixel_valid, frame_done, obj_found} == 4'b0000 && pixel_x == 10'd0 &&
        pixel_y == 10'd0 && obj_x_min == 10'd0 && obj_x_max == 10'd0 && obj_y_min == 10'd0 &&
        obj_y_max == 10'd0 && err_count == 8'd0,
        $sformatf("lk=%0d pv=%0d fd=%0d of=%0d x=%0d y=%0d box=%0d/%0d/%0d/%0d err=%0d",
                  locked, pixel_valid, frame_done, obj_found, pixel_x, pixel_y,
                  obj_x_min, obj_x_max, obj_y_min, obj_y_max, err_count),
        "all zero");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_outputs");
    #2 reset = 1'b1;
    repeat (5) drive(1'b1, 1'b1, 12'h000);

    // Clean stream: lock at 2nd vsync fall, then one frame_done per frame
    pat = 0; send_frame(1'b0, 1'b0, -1);
    push_frm(1'b0, 0, 0, 0, 0);           send_frame(1'b1, 1'b1, -1);
    pat = 1; push_frm(1'b1, 2, 6, 1, 5);  send_frame(1'b1, 1'b0, -1);
    pat = 2; push_frm(1'b1, 0, HA - 1, 0, VA - 1); send_frame(1'b1, 1'b0, -1);
    pat = 0; push_frm(1'b0, 0, HA - 1, 0, VA - 1); send_frame(1'b1, 1'b0, -1);

    // One line too long while locked (partial box in that frame must be discarded), then relock
    pat = 1; send_frame(1'b1, 1'b0, 3);
    pat = 0; send_frame(1'b0, 1'b0, -1);
    push_frm(1'b0, 0, HA - 1, 0, VA - 1); send_frame(1'b1, 1'b1, -1);
    pat = 1; push_frm(1'b1, 2, 6, 1, 5);  send_frame(1'b1, 1'b0, -1);

    // hsync stuck high: error when the line counter reaches 1023
    pat = 0;
    send_line(HT, 1'b1, 0, 1'b0, -1, 1'b0, 0);
    exp_err = sat255(exp_err + 1);
    send_line(1100, 1'b0, 1, 1'b0, 1023, 1'b0, exp_err);
    send_frame(1'b0, 1'b0, -1);

    // Repeated lock/error cycles drive err_count into saturation
    for (int i = 0; i < 258; i++) begin
      send_line(HT + 1, 1'b1, 0, 1'b0, 0, 1'b1, exp_err);
      exp_err = sat255(exp_err + 1);
      send_line(HT, 1'b0, 1, 1'b0, 0, 1'b0, exp_err);
      send_frame(1'b0, 1'b0, -1);
    end

    // Reset in the middle of a locked frame
    send_line(HT, 1'b1, 0, 1'b0, 0, 1'b1, exp_err);
    for (int ln = 1; ln < 4; ln++) send_line(HT, 1'b0, ln, 1'b1, -1, 1'b0, 0);
    send_line(3, 1'b0, 4, 1'b1, -1, 1'b0, 0);
    #3;
    begin
      ev_t e;
      e.lk = 1'b0; e.err = 0; e.at = -1;
      ev_q.push_back(e);
    end
    reset = 1'b0;
    #1;
    chk_zero("reset_midframe");
    hsync = 1'b1; vsync = 1'b1;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    exp_err = 0;
    send_frame(1'b0, 1'b0, -1);
    push_frm(1'b0, 0, 0, 0, 0); send_frame(1'b1, 1'b1, -1);
    send_frame(1'b1, 1'b0, -1);
    repeat (4) drive(1'b1, 1'b1, 12'h000);

    chk("queues_drained", pix_q.size() == 0 && frm_q.size() == 0 && ev_q.size() == 0,
        $sformatf("pix=%0d frm=%0d ev=%0d", pix_q.size(), frm_q.size(), ev_q.size()), "all 0");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
